// File: rtl/wf68k30l_trap_arbiter.sv
// Exception-request arbiter: per-channel sticky pending latches feeding a
// fixed-priority offer/ack sequencer with preemption and double-fault halt.

module wf68k30l_trap_chan #(
   parameter int VEC_W = 8
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic             en,
   input  logic             clr,
   input  logic             ovr_clr,
   input  logic             req,
   input  logic [2:0]       req_type,
   input  logic [VEC_W-1:0] req_vec,
   output logic             pend,
   output logic             ovr,
   output logic [2:0]       typ,
   output logic [VEC_W-1:0] vec
);
   logic pend_kept;

   // The clear is applied first, so a same-cycle request lands on an empty slot.
   assign pend_kept = pend & ~clr;

   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         pend <= 1'b0;
         ovr  <= 1'b0;
         typ  <= '0;
         vec  <= '0;
      end else if (en) begin
         if (req && !pend_kept) begin
            pend <= 1'b1;
            typ  <= req_type;
            vec  <= req_vec;
         end else begin
            pend <= pend_kept;
         end
         ovr <= (ovr & ~ovr_clr) | (req & pend_kept);
      end
   end
endmodule

module wf68k30l_trap_arbiter #(
   parameter int N_SRC   = 4,
   parameter int VEC_W   = 8,
   parameter int PREEMPT = 1,
   parameter int DF_SRC  = 0,
   localparam int SW     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                   CLK,
   input  logic                   RESET_n,
   input  logic [N_SRC-1:0]       REQ,
   input  logic [3*N_SRC-1:0]     REQ_TYPE,
   input  logic [VEC_W*N_SRC-1:0] REQ_VEC,
   input  logic [N_SRC-1:0]       MASK,
   input  logic                   FLUSH,
   input  logic                   TRAP_ACK,
   input  logic                   EXC_DONE,
   output logic                   TRAP_VALID,
   output logic [2:0]             TRAP_TYPE,
   output logic [VEC_W-1:0]       TRAP_VEC,
   output logic [SW-1:0]          TRAP_SRC,
   output logic [N_SRC-1:0]       PENDING,
   output logic [N_SRC-1:0]       OVR,
   output logic                   HALT
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OFFER   = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;
   localparam logic [1:0] S_HALTED  = 2'd3;

   logic [1:0]                  state;
   logic [N_SRC-1:0]            ch_clr;
   logic [N_SRC-1:0][2:0]       ch_typ;
   logic [N_SRC-1:0][VEC_W-1:0] ch_vec;
   logic [N_SRC-1:0]            elig;
   logic [SW-1:0]               win;
   logic                        win_any;

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_ch
         assign ch_clr[gi] = FLUSH |
                             ((state == S_OFFER) && TRAP_ACK && (TRAP_SRC == SW'(gi)));
         wf68k30l_trap_chan #(.VEC_W(VEC_W)) u_ch (
            .CLK      (CLK),
            .RESET_n  (RESET_n),
            .en       (state != S_HALTED),
            .clr      (ch_clr[gi]),
            .ovr_clr  (FLUSH),
            .req      (REQ[gi]),
            .req_type (REQ_TYPE[3*gi +: 3]),
            .req_vec  (REQ_VEC[VEC_W*gi +: VEC_W]),
            .pend     (PENDING[gi]),
            .ovr      (OVR[gi]),
            .typ      (ch_typ[gi]),
            .vec      (ch_vec[gi])
         );
      end
   endgenerate

   assign elig    = PENDING & ~MASK;
   assign win_any = |elig;

   always_comb begin
      win = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (elig[i]) win = SW'(i);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         state      <= S_IDLE;
         TRAP_VALID <= 1'b0;
         TRAP_TYPE  <= '0;
         TRAP_VEC   <= '0;
         TRAP_SRC   <= '0;
         HALT       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!FLUSH && win_any) begin
                  TRAP_TYPE  <= ch_typ[win];
                  TRAP_VEC   <= ch_vec[win];
                  TRAP_SRC   <= win;
                  TRAP_VALID <= 1'b1;
                  state      <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (FLUSH) begin
                  TRAP_VALID <= 1'b0;
                  state      <= S_IDLE;
               end else if (TRAP_ACK) begin
                  TRAP_VALID <= 1'b0;
                  state      <= S_SERVICE;
               end else if (PREEMPT != 0 && win_any && win < TRAP_SRC) begin
                  TRAP_TYPE <= ch_typ[win];
                  TRAP_VEC  <= ch_vec[win];
                  TRAP_SRC  <= win;
               end
            end
            S_SERVICE: begin
               // A fault on the faulting channel while its handler runs is fatal.
               if (REQ[DF_SRC] && TRAP_SRC == SW'(DF_SRC)) begin
                  HALT  <= 1'b1;
                  state <= S_HALTED;
               end else if (EXC_DONE) begin
                  state <= S_IDLE;
               end
            end
            default: TRAP_VALID <= 1'b0;
         endcase
      end
   end
endmodule

// File: doc/wf68k30l_trap_arbiter.md
Name: wf68k30l_trap_arbiter

Overview:
- Parametrised exception-request arbiter sitting between the trap/exception sources and the exception sequencer.
- Generalises the fixed single-trap encoding (NONE, T_1010, T_1111, T_ILLEGAL, T_TRAP, T_PRIV, T_RTE) to N_SRC independent request channels.
- Per channel: a sticky pending latch, a captured 3-bit type code and a captured vector.
- Adds fixed-priority arbitration, a valid/ack offer handshake, optional preemption of unaccepted offers, overrun flags and double-fault halt detection.

Parameters:
- N_SRC, 4, number of request channels; channel 0 is highest priority.
- VEC_W, 8, vector number width per channel.
- PREEMPT, 1, 1 = a higher-priority pending request replaces an unaccepted offer; 0 = the offer is held until TRAP_ACK.
- DF_SRC, 0, channel index whose re-request during its own service causes HALT (bus/address error).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_n  in  1  synchronous active-low reset.
- REQ  in  N_SRC  one-cycle request strobe per channel.
- REQ_TYPE  in  3*N_SRC  per-channel trap type code, slice i = [3i+2:3i].
- REQ_VEC  in  VEC_W*N_SRC  per-channel vector number.
- MASK  in  N_SRC  1 = channel excluded from arbitration; its pending bit is still latched.
- FLUSH  in  1  discard pending requests (pipeline flush).
- TRAP_ACK  in  1  sequencer accepts the current offer.
- EXC_DONE  in  1  sequencer finished exception processing.
- TRAP_VALID  out  1  offer valid.
- TRAP_TYPE  out  3  offered type code.
- TRAP_VEC  out  VEC_W  offered vector.
- TRAP_SRC  out  $clog2(N_SRC)  offered channel index.
- PENDING  out  N_SRC  pending latch contents.
- OVR  out  N_SRC  sticky overrun flags.
- HALT  out  1  double fault; sticky.

Behaviour:
- Reset (RESET_n=0 at a clock edge): state IDLE; PENDING, OVR, HALT, TRAP_VALID, TRAP_TYPE, TRAP_VEC, TRAP_SRC all 0. This applies mid-operation in every state, including HALTED.
- Pending latch, REQ[i]=1 with PENDING[i]=0: set PENDING[i]; capture REQ_TYPE and REQ_VEC slice i.
- Pending latch, REQ[i]=1 with PENDING[i]=1: request dropped, captured data unchanged, OVR[i] set.
- Same-cycle clear (ack) and REQ on the same channel: the clear takes effect, then the new request is latched. Net PENDING[i]=1 with new data; no overrun.
- Eligible set E = PENDING & ~MASK. Winner = lowest index in E.
- States: IDLE, OFFER, SERVICE, HALTED.
- IDLE: if E!=0, register the winner into TRAP_TYPE/VEC/SRC, set TRAP_VALID=1, go to OFFER. Latency: REQ at cycle n -> PENDING at n+1 -> TRAP_VALID at n+2.
- OFFER, TRAP_ACK=1: clear PENDING[TRAP_SRC]; TRAP_VALID=0 next cycle; go to SERVICE. TRAP_TYPE/VEC/SRC hold their values through SERVICE.
- OFFER, no ack, PREEMPT=1, winner index < TRAP_SRC: reload the outputs with the new winner; TRAP_VALID stays 1.
- OFFER, no ack, PREEMPT=0: outputs stable until ack.
- OFFER, winner's MASK rises before ack: offer held; masking never withdraws an offer.
- SERVICE: requests keep latching. EXC_DONE=1 -> IDLE, with re-arbitration next cycle (back-to-back offers are possible, minimum 1 idle cycle).
- SERVICE, REQ[DF_SRC]=1 while TRAP_SRC==DF_SRC: HALT=1 and go to HALTED. Takes precedence over a same-cycle EXC_DONE.
- HALTED: all inputs ignored; TRAP_VALID=0; exit only via reset.
- FLUSH in IDLE or OFFER: PENDING=0, OVR=0, TRAP_VALID=0, state IDLE. FLUSH beats a same-cycle TRAP_ACK, so that offer is not taken.
- FLUSH in SERVICE: clears PENDING and OVR only; state kept.
- FLUSH with a same-cycle REQ: the REQ is latched after the clear and survives.
- TRAP_ACK or EXC_DONE outside their states: ignored.

Test Plan:
- Reset, then REQ[2] with type 3'd4, vec 8'h25 at cycle 0 -> PENDING=4'b0100 at cycle 1; TRAP_VALID=1, TRAP_SRC=2, TRAP_VEC=8'h25 at cycle 2. ACK -> PENDING=0, TRAP_VALID=0.
- REQ[3] offered and unacked, then REQ[1] (vec 8'h0C) arrives with PREEMPT=1 -> offer switches to SRC=1/8'h0C. Repeat with PREEMPT=0 -> SRC stays 3.
- REQ[1] twice while pending, second vec 8'h99 -> OVR[1]=1, offered vec keeps the first value. FLUSH -> PENDING=0, OVR=0.
- ACK on channel 0 and REQ[0] in the same cycle -> PENDING[0] stays 1 with the new vector. Channel-0 REQ during SERVICE of channel 0 -> HALT=1. Further REQs give no offer until RESET_n=0.
- MASK=4'b0001 with REQ[0] and REQ[2] -> SRC=2 offered first. Unmask after EXC_DONE -> SRC=0 offered next.
